// File: rtl/comp_req_engine_if.sv
// Request, comparator and response signals shared by comp_req_engine and its neighbours.
// Latency: none; this file only groups wires.
// Backpressure: valid/ready on the request and response channels. The comparator side has no handshake.
`timescale 1ns/1ps
interface comp_req_engine_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_y1;
    logic             cmp_y2;
    logic             cmp_y3;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_code;
    logic             rsp_err;

    // Engine side: takes requests, drives the comparator, produces responses.
    modport master (
        input  req_valid, req_a, req_b, cmp_y1, cmp_y2, cmp_y3, rsp_ready,
        output req_ready, cmp_a, cmp_b, rsp_valid, rsp_code, rsp_err
    );

    // Environment side: the request source, the comparator and the response sink.
    modport slave (
        output req_valid, req_a, req_b, cmp_y1, cmp_y2, cmp_y3, rsp_ready,
        input  req_ready, cmp_a, cmp_b, rsp_valid, rsp_code, rsp_err
    );
endinterface

// File: rtl/comp_req_engine.sv
// Drives operand pairs into an external comparator, samples its one-hot flags and checks them against an internal compare.
// Latency: the flags are sampled SETTLE_CYC edges after the request is accepted, and rsp_valid rises at that same edge.
// Backpressure: req_ready is high only in IDLE. Under rsp stall, rsp_* and cmp_* hold. Counters exist only with COMP_REQ_STATS_EN.
`timescale 1ns/1ps
module comp_req_engine #(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    comp_req_engine_if.master   bus,
    input  logic                stats_clr,
    output logic [CNT_W-1:0]    cnt_lt,
    output logic [CNT_W-1:0]    cnt_eq,
    output logic [CNT_W-1:0]    cnt_gt,
    output logic [CNT_W-1:0]    cnt_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

    state_t           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [1:0]       code_q, code_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;
    logic [1:0]       flag_code;
    logic [1:0]       ref_code;

    // Decode the comparator flags and compute the expected code from the held operands.
    always_comb begin
        flag_code = 2'b00;
        case ({bus.cmp_y1, bus.cmp_y2, bus.cmp_y3})
            3'b100:  flag_code = 2'b01;
            3'b010:  flag_code = 2'b10;
            3'b001:  flag_code = 2'b11;
            default: flag_code = 2'b00;
        endcase
        if (a_q < b_q)       ref_code = 2'b01;
        else if (a_q == b_q) ref_code = 2'b10;
        else                 ref_code = 2'b11;
    end

    // Next-state logic: accept the request, count out the settle time, sample, then hold the response.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        a_d         = a_q;
        b_d         = b_q;
        settle_d    = settle_q;
        code_d      = code_q;
        err_d       = err_q;
        vld_d       = vld_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    a_d         = bus.req_a;
                    b_d         = bus.req_b;
                    settle_d    = SETTLE_LOAD;
                    state_d     = SETTLE;
                    req_ready_d = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SW'(1);
                end else begin
                    code_d  = flag_code;
                    err_d   = (flag_code == 2'b00) || (flag_code != ref_code);
                    vld_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    vld_d       = 1'b0;
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                vld_d       = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            settle_q    <= '0;
            code_q      <= 2'b00;
            err_q       <= 1'b0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            a_q         <= a_d;
            b_q         <= b_d;
            settle_q    <= settle_d;
            code_q      <= code_d;
            err_q       <= err_d;
            vld_q       <= vld_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.cmp_a     = a_q;
    assign bus.cmp_b     = b_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_code  = code_q;
    assign bus.rsp_err   = err_q;

`ifdef COMP_REQ_STATS_EN
    logic             rsp_hs;
    logic [CNT_W-1:0] lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, er_q, er_d;

    assign rsp_hs = vld_q && bus.rsp_ready;

    // Saturating counters, updated at each response handshake. A clear overrides a same-cycle increment.
    always_comb begin
        lt_d = lt_q;
        eq_d = eq_q;
        gt_d = gt_q;
        er_d = er_q;
        if (stats_clr) begin
            lt_d = '0;
            eq_d = '0;
            gt_d = '0;
            er_d = '0;
        end else if (rsp_hs) begin
            if (err_q) begin
                if (er_q != '1) er_d = er_q + CNT_W'(1);
            end else begin
                case (code_q)
                    2'b01:   if (lt_q != '1) lt_d = lt_q + CNT_W'(1);
                    2'b10:   if (eq_q != '1) eq_d = eq_q + CNT_W'(1);
                    2'b11:   if (gt_q != '1) gt_d = gt_q + CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lt_q <= '0;
            eq_q <= '0;
            gt_q <= '0;
            er_q <= '0;
        end else begin
            lt_q <= lt_d;
            eq_q <= eq_d;
            gt_q <= gt_d;
            er_q <= er_d;
        end
    end

    assign cnt_lt  = lt_q;
    assign cnt_eq  = eq_q;
    assign cnt_gt  = gt_q;
    assign cnt_err = er_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign cnt_lt  = '0;
    assign cnt_eq  = '0;
    assign cnt_gt  = '0;
    assign cnt_err = '0;
`endif
endmodule

// File: tb/tb_comp_req_engine.sv
// Bench for comp_req_engine with two instances: SETTLE_CYC=1 with CNT_W=2, and SETTLE_CYC=4 with CNT_W=16.
// Latency: transactions are driven cycle by cycle, and each response is expected at a fixed edge.
// Backpressure: rsp_ready is held low for a chosen number of cycles before each response is taken.
`timescale 1ns/1ps
module tb_comp_req_engine;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst4_n, clr0, clr4;
    logic frc0;
    logic [2:0] ffl0;
    logic [1:0]  c0_lt, c0_eq, c0_gt, c0_er;
    logic [15:0] c4_lt, c4_eq, c4_gt, c4_er;

    comp_req_engine_if #(.WIDTH(8)) if0 ();
    comp_req_engine_if #(.WIDTH(8)) if4 ();

    // Comparator models: honest unsigned compare, with an override for fault injection on if0.
    assign if0.cmp_y1 = frc0 ? ffl0[2] : (if0.cmp_a <  if0.cmp_b);
    assign if0.cmp_y2 = frc0 ? ffl0[1] : (if0.cmp_a == if0.cmp_b);
    assign if0.cmp_y3 = frc0 ? ffl0[0] : (if0.cmp_a >  if0.cmp_b);
    assign if4.cmp_y1 = (if4.cmp_a <  if4.cmp_b);
    assign if4.cmp_y2 = (if4.cmp_a == if4.cmp_b);
    assign if4.cmp_y3 = (if4.cmp_a >  if4.cmp_b);

    comp_req_engine #(.WIDTH(8), .SETTLE_CYC(1), .CNT_W(2)) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .bus(if0), .stats_clr(clr0),
        .cnt_lt(c0_lt), .cnt_eq(c0_eq), .cnt_gt(c0_gt), .cnt_err(c0_er)
    );
    comp_req_engine #(.WIDTH(8), .SETTLE_CYC(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .bus(if4), .stats_clr(clr4),
        .cnt_lt(c4_lt), .cnt_eq(c4_eq), .cnt_gt(c4_gt), .cnt_err(c4_er)
    );

    int total = 0;
    int bad = 0;
    int m_lt = 0, m_eq = 0, m_gt = 0, m_er = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       frc;
        logic [2:0] fl;
        logic [1:0] code;
        logic       err;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Code implied by a flag pattern: valid only when exactly one flag is set.
    function automatic logic [1:0] flag_code(input logic [2:0] fl);
        if ($countones(fl) != 1) return 2'b00;
        if (fl[2]) return 2'b01;
        if (fl[1]) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [1:0] true_code(input logic [7:0] a, input logic [7:0] b);
        if (a < b) return 2'b01;
        if (a == b) return 2'b10;
        return 2'b11;
    endfunction

    // Statistics model, updated at a response handshake. Counters stay 0 when the feature is not built.
    task automatic model_hs(input logic [1:0] code, input logic err, input logic clr);
`ifdef COMP_REQ_STATS_EN
        if (clr) begin
            m_lt = 0; m_eq = 0; m_gt = 0; m_er = 0;
        end else if (err) begin
            m_er = sat(m_er);
        end else begin
            case (code)
                2'b01: m_lt = sat(m_lt);
                2'b10: m_eq = sat(m_eq);
                2'b11: m_gt = sat(m_gt);
                default: ;
            endcase
        end
`else
        if (clr || err || code != 2'b00) begin
            m_lt = 0;
        end
`endif
    endtask

    task automatic chk_cnt0(input string tag);
        chk({tag, "_cnt_lt"},  32'(c0_lt), 32'(m_lt));
        chk({tag, "_cnt_eq"},  32'(c0_eq), 32'(m_eq));
        chk({tag, "_cnt_gt"},  32'(c0_gt), 32'(m_gt));
        chk({tag, "_cnt_err"}, 32'(c0_er), 32'(m_er));
    endtask

    // One complete transaction on the SETTLE_CYC=1 instance, with the response held off for dly cycles.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic frc,
                           input logic [2:0] fl, input logic [1:0] ecode, input logic eerr,
                           input int dly, input logic clr, input string tag);
        if0.req_valid = 1'b1;
        if0.req_a = a;
        if0.req_b = b;
        frc0 = frc;
        ffl0 = fl;
        chk({tag, "_rdy_idle"}, 32'(if0.req_ready), 32'd1);
        step;
        if0.req_valid = 1'b0;
        chk({tag, "_vld_settle"}, 32'(if0.rsp_valid), 32'd0);
        chk({tag, "_rdy_settle"}, 32'(if0.req_ready), 32'd0);
        chk({tag, "_cmp_a"}, 32'(if0.cmp_a), 32'(a));
        chk({tag, "_cmp_b"}, 32'(if0.cmp_b), 32'(b));
        step;
        frc0 = 1'b0;
        chk({tag, "_vld"}, 32'(if0.rsp_valid), 32'd1);
        chk({tag, "_code"}, 32'(if0.rsp_code), 32'(ecode));
        chk({tag, "_err"}, 32'(if0.rsp_err), 32'(eerr));
        for (int i = 0; i < dly; i++) begin
            step;
            chk({tag, "_stall_vld"}, 32'(if0.rsp_valid), 32'd1);
            chk({tag, "_stall_code"}, 32'(if0.rsp_code), 32'(ecode));
        end
        if0.rsp_ready = 1'b1;
        clr0 = clr;
        step;
        if0.rsp_ready = 1'b0;
        clr0 = 1'b0;
        model_hs(ecode, eerr, clr);
        chk({tag, "_vld_done"}, 32'(if0.rsp_valid), 32'd0);
        chk({tag, "_rdy_done"}, 32'(if0.req_ready), 32'd1);
        chk_cnt0(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ra, rb;
        logic rf;
        logic [2:0] rfl;
        logic [1:0] ec;
        logic ee;

        vecs[0] = '{8'h03, 8'h09, 1'b0, 3'b000, 2'b01, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 3'b000, 2'b10, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b0, 3'b000, 2'b11, 1'b0};
        vecs[3] = '{8'h04, 8'h04, 1'b1, 3'b110, 2'b00, 1'b1};
        vecs[4] = '{8'h02, 8'h07, 1'b1, 3'b001, 2'b11, 1'b1};
        vecs[5] = '{8'h05, 8'h05, 1'b1, 3'b000, 2'b00, 1'b1};
        vecs[6] = '{8'h00, 8'h01, 1'b1, 3'b010, 2'b10, 1'b1};
        vecs[7] = '{8'h80, 8'h7F, 1'b1, 3'b001, 2'b11, 1'b0};

        rst0_n = 1'b0; rst4_n = 1'b0; clr0 = 1'b0; clr4 = 1'b0;
        frc0 = 1'b0; ffl0 = 3'b000;
        if0.req_valid = 1'b1; if0.req_a = 8'h5A; if0.req_b = 8'hA5; if0.rsp_ready = 1'b1;
        if4.req_valid = 1'b0; if4.req_a = 8'h00; if4.req_b = 8'h00; if4.rsp_ready = 1'b0;
        repeat (3) step;
        chk("rst_rdy", 32'(if0.req_ready), 32'd1);
        chk("rst_vld", 32'(if0.rsp_valid), 32'd0);
        chk("rst_cmp_a", 32'(if0.cmp_a), 32'd0);
        chk("rst_cmp_b", 32'(if0.cmp_b), 32'd0);
        chk("rst_code", 32'(if0.rsp_code), 32'd0);
        chk("rst_err", 32'(if0.rsp_err), 32'd0);
        chk("rst4_rdy", 32'(if4.req_ready), 32'd1);
        chk("rst4_cnt_lt", 32'(c4_lt), 32'd0);
        chk_cnt0("rst");
        if0.req_valid = 1'b0; if0.rsp_ready = 1'b0;
        rst0_n = 1'b1; rst4_n = 1'b1;
        step;

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i].a, vecs[i].b, vecs[i].frc, vecs[i].fl, vecs[i].code, vecs[i].err,
                    i % 3, 1'b0, $sformatf("vec%0d", i));

        // Backpressure: five stalled cycles with a competing request that must be ignored.
        if0.req_valid = 1'b1; if0.req_a = 8'h40; if0.req_b = 8'h41;
        step;
        if0.req_valid = 1'b0;
        step;
        chk("bp_vld_rise", 32'(if0.rsp_valid), 32'd1);
        if0.req_valid = 1'b1; if0.req_a = 8'hAA; if0.req_b = 8'hBB;
        for (int i = 0; i < 5; i++) begin
            step;
            chk("bp_vld", 32'(if0.rsp_valid), 32'd1);
            chk("bp_code", 32'(if0.rsp_code), 32'd1);
            chk("bp_cmp_a", 32'(if0.cmp_a), 32'h40);
            chk("bp_cmp_b", 32'(if0.cmp_b), 32'h41);
            chk("bp_rdy", 32'(if0.req_ready), 32'd0);
        end
        if0.req_valid = 1'b0;
        if0.rsp_ready = 1'b1;
        step;
        if0.rsp_ready = 1'b0;
        model_hs(2'b01, 1'b0, 1'b0);
        chk("bp_release_vld", 32'(if0.rsp_valid), 32'd0);
        chk("bp_release_rdy", 32'(if0.req_ready), 32'd1);
        chk_cnt0("bp");

        // Statistics: clear, then five lt responses saturate a 2-bit counter.
        run_txn(8'h01, 8'h01, 1'b0, 3'b000, 2'b10, 1'b0, 0, 1'b1, "st_clr0");
        for (int i = 0; i < 5; i++)
            run_txn(8'(i), 8'(i + 10), 1'b0, 3'b000, 2'b01, 1'b0, 0, 1'b0, "st_lt");
`ifdef COMP_REQ_STATS_EN
        chk("stats_lt_sat", 32'(c0_lt), 32'd3);
`else
        chk("stats_lt_off", 32'(c0_lt), 32'd0);
`endif
        run_txn(8'h09, 8'h02, 1'b1, 3'b111, 2'b00, 1'b1, 1, 1'b1, "st_clr_hs");
        chk("stats_clr_lt", 32'(c0_lt), 32'd0);
        chk("stats_clr_err", 32'(c0_er), 32'd0);

        // Randomized transactions against the reference rules.
        for (int n = 0; n < 150; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            rf = ($urandom_range(0, 3) == 0);
            rfl = 3'($urandom);
            ec = rf ? flag_code(rfl) : true_code(ra, rb);
            ee = (ec == 2'b00) || (ec != true_code(ra, rb));
            run_txn(ra, rb, rf, rfl, ec, ee, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0), "rnd");
        end

        // SETTLE_CYC=4: the response appears exactly four edges after acceptance.
        if4.req_valid = 1'b1; if4.req_a = 8'h10; if4.req_b = 8'h20;
        step;
        if4.req_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step;
            chk("s4_vld_early", 32'(if4.rsp_valid), 32'd0);
        end
        step;
        chk("s4_vld", 32'(if4.rsp_valid), 32'd1);
        chk("s4_code", 32'(if4.rsp_code), 32'd1);
        chk("s4_err", 32'(if4.rsp_err), 32'd0);
        if4.rsp_ready = 1'b1;
        step;
        if4.rsp_ready = 1'b0;
        chk("s4_done", 32'(if4.rsp_valid), 32'd0);

        // Reset during the second settle cycle discards the request.
        if4.req_valid = 1'b1; if4.req_a = 8'h33; if4.req_b = 8'h11;
        step;
        if4.req_valid = 1'b0;
        step;
        rst4_n = 1'b0;
        step;
        rst4_n = 1'b1;
        chk("mrst_rdy", 32'(if4.req_ready), 32'd1);
        chk("mrst_cmp_a", 32'(if4.cmp_a), 32'd0);
        chk("mrst_cmp_b", 32'(if4.cmp_b), 32'd0);
        chk("mrst_cnt_lt", 32'(c4_lt), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step;
            chk("mrst_no_vld", 32'(if4.rsp_valid), 32'd0);
        end

        // Reset on the SETTLE_CYC=1 instance clears its counters.
        rst0_n = 1'b0;
        step;
        rst0_n = 1'b1;
        m_lt = 0; m_eq = 0; m_gt = 0; m_er = 0;
        chk_cnt0("rst_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
